// File: rtl/fusion_alu_pkg.sv
// Shared opcode encodings, shift-op helper and FSM state type for the
// Fusion-Core execute stage.
package fusion_alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'd6;
  localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'd9;
  localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'd10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_single_cycle_unit.sv
// Combinational evaluation of all non-shift opcodes, built from the small
// 32-bit op units (logic, add/sub, compare) defined alongside it.
module alu_logic_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] and_o,
  output logic [W-1:0] or_o,
  output logic [W-1:0] xor_o
);
  assign and_o = a_i & b_i;
  assign or_o  = a_i | b_i;
  assign xor_o = a_i ^ b_i;
endmodule

module alu_addsub_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);
  // Wraps modulo 2^W; carry-out is intentionally not produced.
  assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);
endmodule

module alu_compare_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         ltu_o
);
  assign lt_o  = $signed(a_i) < $signed(b_i);
  assign ltu_o = a_i < b_i;
endmodule

module alu_single_cycle_unit
  import fusion_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                illegal_o
);

  logic [DATA_W-1:0] andRes;
  logic [DATA_W-1:0] orRes;
  logic [DATA_W-1:0] xorRes;
  logic [DATA_W-1:0] sumRes;
  logic              ltRes;
  logic              ltuRes;

  alu_logic_unit #(.W(DATA_W)) u_logic (
    .a_i   (a_i),
    .b_i   (b_i),
    .and_o (andRes),
    .or_o  (orRes),
    .xor_o (xorRes)
  );

  alu_addsub_unit #(.W(DATA_W)) u_addsub (
    .a_i   (a_i),
    .b_i   (b_i),
    .sub_i (op_i == OP_SUB),
    .sum_o (sumRes)
  );

  alu_compare_unit #(.W(DATA_W)) u_compare (
    .a_i   (a_i),
    .b_i   (b_i),
    .lt_o  (ltRes),
    .ltu_o (ltuRes)
  );

  // Shift opcodes are legal but evaluated by the iterative path in the stage.
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: result_o = sumRes;
      OP_AND:         result_o = andRes;
      OP_OR:          result_o = orRes;
      OP_XOR:         result_o = xorRes;
      OP_SLT:         result_o = {{(DATA_W-1){1'b0}}, ltRes};
      OP_SLTU:        result_o = {{(DATA_W-1){1'b0}}, ltuRes};
      OP_SLL, OP_SRL, OP_SRA: result_o = '0;
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ops complete in one edge, shifts
// walk one bit per cycle through a two-state FSM before reaching the output slot.
module alu_exec_stage
  import fusion_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [RD_W-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_zero,
  output logic                out_illegal,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [RD_W-1:0]     rd_q, rd_d;

  logic                outValid_q, outValid_d;
  logic [DATA_W-1:0]   outResult_q, outResult_d;
  logic [RD_W-1:0]     outRd_q, outRd_d;
  logic                outZero_q, outZero_d;
  logic                outIllegal_q, outIllegal_d;

  logic [DATA_W-1:0]   scResult;
  logic                scIllegal;
  logic [DATA_W-1:0]   accShifted;
  logic                accept;
  logic                acceptShift;
  logic                acceptSingle;
  logic                shiftDone;

  alu_single_cycle_unit #(.DATA_W(DATA_W)) u_single (
    .op_i      (in_op),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (scResult),
    .illegal_o (scIllegal)
  );

  assign accept       = in_valid && in_ready;
  assign acceptShift  = accept && is_shift(in_op);
  assign acceptSingle = accept && !is_shift(in_op);
  assign shiftDone    = (state_q == ST_SHIFT) && (cnt_q == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (acceptShift) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 5'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // in_ready may follow out_ready combinationally; output data never does.
  always_comb begin
    busy     = (state_q == ST_SHIFT);
    in_ready = (state_q == ST_IDLE) && (!outValid_q || out_ready) && rst_n;
  end

  always_comb begin
    case (op_q)
      OP_SLL:  accShifted = {acc_q[DATA_W-2:0], 1'b0};
      OP_SRL:  accShifted = {1'b0, acc_q[DATA_W-1:1]};
      default: accShifted = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    rd_d  = rd_q;
    if (acceptShift) begin
      acc_d = in_a;
      cnt_d = in_b[4:0];
      op_d  = in_op;
      rd_d  = in_rd;
    end else if ((state_q == ST_SHIFT) && (cnt_q != 5'd0)) begin
      acc_d = accShifted;
      cnt_d = cnt_q - 5'd1;
    end
  end

  // A reload in the same cycle as a transfer keeps the slot occupied.
  always_comb begin
    outValid_d   = outValid_q && !out_ready;
    outResult_d  = outResult_q;
    outRd_d      = outRd_q;
    outZero_d    = outZero_q;
    outIllegal_d = outIllegal_q;
    if (acceptSingle) begin
      outValid_d   = 1'b1;
      outResult_d  = scResult;
      outRd_d      = in_rd;
      outZero_d    = (scResult == '0);
      outIllegal_d = scIllegal;
    end else if (shiftDone) begin
      outValid_d   = 1'b1;
      outResult_d  = acc_q;
      outRd_d      = rd_q;
      outZero_d    = (acc_q == '0);
      outIllegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      outValid_q   <= 1'b0;
      outResult_q  <= '0;
      outRd_q      <= '0;
      outZero_q    <= 1'b0;
      outIllegal_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      outValid_q   <= outValid_d;
      outResult_q  <= outResult_d;
      outRd_q      <= outRd_d;
      outZero_q    <= outZero_d;
      outIllegal_q <= outIllegal_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_result  = outResult_q;
  assign out_rd      = outRd_q;
  assign out_zero    = outZero_q;
  assign out_illegal = outIllegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: a transaction-level model tracks the
// output slot and in-flight shift by due cycle, plus directed literal checks.
module tb_alu_exec_stage;
  import fusion_alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_zero;
  logic              out_illegal;
  logic              busy;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the opcode table: {illegal, result}.
  function automatic logic [32:0] refOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sra;
    int sh;
    sh  = int'(b[4:0]);
    sra = $signed(a) >>> sh;
    case (op)
      OP_ADD:  return {1'b0, a + b};
      OP_SUB:  return {1'b0, a - b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_SLT:  return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      OP_SLTU: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      OP_SLL:  return {1'b0, a << sh};
      OP_SRL:  return {1'b0, a >> sh};
      OP_SRA:  return {1'b0, sra};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Model state: output slot contents plus one pending shift with its due cycle.
  logic        mValid = 1'b0;
  logic        mPending = 1'b0;
  logic [31:0] mResult = '0;
  logic [4:0]  mRd = '0;
  logic        mIllegal = 1'b0;
  logic [31:0] pendResult = '0;
  logic [4:0]  pendRd = '0;
  int          mDue = 0;
  int          cyc = 0;
  logic        expReady;
  logic        nAccept = 1'b0;
  logic [3:0]  nOp;
  logic [31:0] nA, nB;
  logic [4:0]  nRd;

  // Compare DUT against the model mid-cycle, and latch this cycle's handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      mValid   = 1'b0;
      mPending = 1'b0;
    end
    expReady = rst_n && !mPending && (!mValid || out_ready);
    nAccept  = in_valid && expReady;
    nOp = in_op;
    nA  = in_a;
    nB  = in_b;
    nRd = in_rd;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("busy", 32'(busy), 32'(mPending));
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    if (!rst_n) begin
      checkOutput("rst_result", out_result, 32'd0);
      checkOutput("rst_rd", 32'(out_rd), 32'd0);
      checkOutput("rst_zero", 32'(out_zero), 32'd0);
      checkOutput("rst_illegal", 32'(out_illegal), 32'd0);
    end else if (mValid) begin
      checkOutput("result", out_result, mResult);
      checkOutput("rd", 32'(out_rd), 32'(mRd));
      checkOutput("zero", 32'(out_zero), 32'(mResult == 32'd0));
      checkOutput("illegal", 32'(out_illegal), 32'(mIllegal));
    end
  end

  // Advance the model at each clock edge using the handshake latched above.
  always @(posedge clk) begin
    logic [32:0] r;
    if (rst_n) begin
      cyc++;
      if (mValid && out_ready) mValid = 1'b0;
      if (mPending && cyc == mDue) begin
        mValid   = 1'b1;
        mResult  = pendResult;
        mRd      = pendRd;
        mIllegal = 1'b0;
        mPending = 1'b0;
      end
      if (nAccept) begin
        r = refOp(nOp, nA, nB);
        if (nOp == OP_SLL || nOp == OP_SRL || nOp == OP_SRA) begin
          mPending   = 1'b1;
          mDue       = cyc + 1 + int'(nB[4:0]);
          pendResult = r[31:0];
          pendRd     = nRd;
        end else begin
          mValid   = 1'b1;
          mResult  = r[31:0];
          mIllegal = r[32];
          mRd      = nRd;
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until the edge that accepts it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    #1;
    while (!in_ready && waitCycles < 200) begin
      stepCycle();
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      stepCycle();
      in_valid = 1'b0;
    end
  endtask

  task automatic waitResult(output int latency, output int busyCycles);
    latency    = 0;
    busyCycles = 0;
    while (!out_valid && latency < 100) begin
      if (busy) busyCycles++;
      checkOutput("shift_in_ready_low", 32'(in_ready), 32'd0);
      stepCycle();
      latency++;
    end
  endtask

  initial begin
    int lat, bc;
    logic [3:0] opsList [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
    logic [31:0] specials [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_rd     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] ADD wrap to zero");
    out_ready = 1'b1;
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3);
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_result", out_result, 32'd0);
    checkOutput("add_zero", 32'(out_zero), 32'd1);
    checkOutput("add_rd", 32'(out_rd), 32'd3);

    $display("[TB] back-to-back XOR then SLT");
    applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd7);
    checkOutput("xor_result", out_result, 32'h0F0F_F0F0);
    checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(OP_SLT, 32'h8000_0000, 32'd1, 5'd8);
    checkOutput("slt_result", out_result, 32'd1);
    checkOutput("slt_valid", 32'(out_valid), 32'd1);
    repeat (2) stepCycle();

    $display("[TB] SRA and SRL by 4");
    applyStimulus(OP_SRA, 32'h8000_0010, 32'h24, 5'd9);
    waitResult(lat, bc);
    checkOutput("sra_busy_cycles", 32'(bc), 32'd5);
    checkOutput("sra_latency", 32'(lat), 32'd5);
    checkOutput("sra_result", out_result, 32'hF800_0001);
    stepCycle();
    applyStimulus(OP_SRL, 32'h8000_0010, 32'h24, 5'd10);
    waitResult(lat, bc);
    checkOutput("srl_latency", 32'(lat), 32'd5);
    checkOutput("srl_result", out_result, 32'h0800_0001);
    stepCycle();

    $display("[TB] output hold under backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 32'd2, 32'd3, 5'd4);
    in_valid = 1'b1;
    in_op    = OP_OR;
    in_a     = 32'h0F;
    in_b     = 32'hF0;
    in_rd    = 5'd5;
    repeat (4) begin
      checkOutput("hold_result", out_result, 32'd5);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      stepCycle();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("reload_result", out_result, 32'h0000_00FF);
    checkOutput("reload_rd", 32'(out_rd), 32'd5);
    checkOutput("reload_valid", 32'(out_valid), 32'd1);
    stepCycle();

    $display("[TB] reset in the middle of a long shift");
    applyStimulus(OP_SLL, 32'd1, 32'd31, 5'd6);
    repeat (10) stepCycle();
    checkOutput("midshift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(OP_ADD, 32'd10, 32'd20, 5'd11);
    checkOutput("post_rst_add", out_result, 32'd30);
    checkOutput("post_rst_rd", 32'(out_rd), 32'd11);
    applyStimulus(4'hF, 32'd5, 32'd6, 5'd12);
    checkOutput("illegal_result", out_result, 32'd0);
    checkOutput("illegal_flag", 32'(out_illegal), 32'd1);
    checkOutput("illegal_valid", 32'(out_valid), 32'd1);
    stepCycle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = ($urandom_range(0, 9) < 8) ? opsList[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
      in_a      = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      in_rd     = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
